pcs_stream_checker: RTL and testbench

PCS_STREAM_CHECKER -- requirements
Module: pcs_stream_checker

---
 rtl/pcs_stream_checker.sv | 115 +++++++++++
 tb/tb_pcs_stream_checker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pcs_stream_checker.sv
// pcs_stream_checker: aligns a PCS output stream against a queued golden stream and
// keeps match/mismatch/underflow statistics with first-mismatch capture.
module pcs_stream_checker #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int SKIP_CNT   = 3,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_enable,
   input  logic                          i_clear,
   input  logic [DATA_WIDTH-1:0]         i_exp_data,
   input  logic                          i_exp_valid,
   output logic                          o_exp_ready,
   input  logic [DATA_WIDTH-1:0]         i_dut_data,
   input  logic                          i_dut_valid,
   output logic [1:0]                    o_state,
   output logic [CNT_WIDTH-1:0]          o_match_cnt,
   output logic [CNT_WIDTH-1:0]          o_mismatch_cnt,
   output logic [CNT_WIDTH-1:0]          o_underflow_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
   output logic                          o_error,
   output logic [DATA_WIDTH-1:0]         o_first_err_exp,
   output logic [DATA_WIDTH-1:0]         o_first_err_dut,
   output logic [CNT_WIDTH-1:0]          o_first_err_idx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int SW = $clog2(SKIP_CNT + 2);
   typedef enum logic [1:0] {IDLE = 2'd0, SKIP = 2'd1, CHECK = 2'd2} state_t;
   state_t state, state_nx;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [AW:0]           level;
   logic [SW-1:0]         skip_cnt;
   logic                  push, pop, sample, under, skip_take, last_skip;
   logic                  pend_valid, pend_under, pend_match;
   logic [DATA_WIDTH-1:0] pend_exp, pend_dut;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return v + CNT_WIDTH'(v != '1);
   endfunction

   assign o_exp_ready  = level < (AW+1)'(FIFO_DEPTH);
   assign o_fifo_level = level;
   assign o_state      = state;
   assign push         = i_exp_valid && o_exp_ready && !i_clear;
   assign sample       = i_enable && i_dut_valid && !i_clear && state == CHECK;
   assign pop          = sample && level != '0;
   assign under        = sample && level == '0;
   assign skip_take    = i_enable && i_dut_valid && !i_clear && state == SKIP;
   assign last_skip    = skip_cnt == SW'(SKIP_CNT - 1);

   always_ff @(posedge i_clk)
      if (i_reset) state <= IDLE;
      else         state <= state_nx;

   always_comb begin
      state_nx = !i_enable ? IDLE :
                 i_clear ? state :
                 state == IDLE ? (SKIP_CNT > 0 ? SKIP : CHECK) :
                 (skip_take && last_skip) ? CHECK : state;
   end

   always_ff @(posedge i_clk)
      if (push) mem[wr_ptr] <= i_exp_data;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         level           <= '0;
         skip_cnt        <= '0;
         pend_valid      <= 1'b0;
         pend_under      <= 1'b0;
         pend_match      <= 1'b0;
         pend_exp        <= '0;
         pend_dut        <= '0;
         o_match_cnt     <= '0;
         o_mismatch_cnt  <= '0;
         o_underflow_cnt <= '0;
         o_error         <= 1'b0;
         o_first_err_exp <= '0;
         o_first_err_dut <= '0;
         o_first_err_idx <= '0;
      end else begin
         wr_ptr     <= wr_ptr + AW'(push);
         rd_ptr     <= rd_ptr + AW'(pop);
         level      <= level + (AW+1)'(push) - (AW+1)'(pop);
         skip_cnt   <= state != SKIP ? '0 : skip_cnt + SW'(skip_take);
         pend_valid <= sample;
         pend_under <= under;
         pend_match <= mem[rd_ptr] == i_dut_data;
         pend_exp   <= mem[rd_ptr];
         pend_dut   <= i_dut_data;
         // a result whose enable has since dropped is stale and is dropped
         if (pend_valid && i_enable) begin
            if (pend_under) begin
               o_underflow_cnt <= sat_inc(o_underflow_cnt);
               o_error         <= 1'b1;
            end else if (pend_match) begin
               o_match_cnt <= sat_inc(o_match_cnt);
            end else begin
               o_mismatch_cnt <= sat_inc(o_mismatch_cnt);
               o_error        <= 1'b1;
               if (o_mismatch_cnt == '0) begin
                  o_first_err_exp <= pend_exp;
                  o_first_err_dut <= pend_dut;
                  o_first_err_idx <= o_match_cnt;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_pcs_stream_checker.sv
// tb_pcs_stream_checker: directed table plus hand sequences for pcs_stream_checker.
module tb_pcs_stream_checker;
   logic        i_clk = 1'b0;
   logic        i_reset, i_enable, i_clear, i_exp_valid, i_dut_valid;
   logic [31:0] i_exp_data, i_dut_data;
   logic        o_exp_ready, o_error;
   logic [1:0]  o_state;
   logic [31:0] o_match_cnt, o_mismatch_cnt, o_underflow_cnt;
   logic [4:0]  o_fifo_level;
   logic [31:0] o_first_err_exp, o_first_err_dut, o_first_err_idx;
   int checks = 0, errors = 0;

   typedef struct {
      logic        en, ev, dv;
      logic [31:0] ed, dd;
      logic [1:0]  st;
      logic [4:0]  lvl;
      logic [31:0] m;
      logic        err;
   } vec_t;
   vec_t tbl[$];

   pcs_stream_checker dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_clear(i_clear),
      .i_exp_data(i_exp_data), .i_exp_valid(i_exp_valid), .o_exp_ready(o_exp_ready),
      .i_dut_data(i_dut_data), .i_dut_valid(i_dut_valid), .o_state(o_state),
      .o_match_cnt(o_match_cnt), .o_mismatch_cnt(o_mismatch_cnt),
      .o_underflow_cnt(o_underflow_cnt), .o_fifo_level(o_fifo_level), .o_error(o_error),
      .o_first_err_exp(o_first_err_exp), .o_first_err_dut(o_first_err_dut),
      .o_first_err_idx(o_first_err_idx)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic en, input logic ev, input logic [31:0] ed,
                      input logic dv, input logic [31:0] dd);
      i_enable = en; i_exp_valid = ev; i_exp_data = ed; i_dut_valid = dv; i_dut_data = dd;
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic add(input logic en, input logic ev, input logic [31:0] ed, input logic dv,
                      input logic [31:0] dd, input logic [1:0] st, input int lvl, input int m);
      vec_t v;
      v.en = en; v.ev = ev; v.ed = ed; v.dv = dv; v.dd = dd;
      v.st = st; v.lvl = 5'(lvl); v.m = 32'(m); v.err = 1'b0;
      tbl.push_back(v);
   endtask

   int max_lvl;

   initial begin
      // basic alignment: 8 pushes, enable, 3 junk samples, then the 8 words
      for (int i = 0; i < 8; i++) add(0, 1, 32'(i + 1), 0, 0, 2'd0, i + 1, 0);
      add(1, 0, 0, 0, 0, 2'd1, 8, 0);
      add(1, 0, 0, 1, 32'hF00D_0000, 2'd1, 8, 0);
      add(1, 0, 0, 1, 32'hF00D_0001, 2'd1, 8, 0);
      add(1, 0, 0, 1, 32'hF00D_0002, 2'd2, 8, 0);
      for (int k = 0; k < 8; k++) add(1, 0, 0, 1, 32'(k + 1), 2'd2, 7 - k, k);
      add(1, 0, 0, 0, 0, 2'd2, 0, 8);

      i_reset = 1; i_clear = 0;
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      i_reset = 0;
      chk("rst_state", o_state, 0);
      chk("rst_level", o_fifo_level, 0);
      chk("rst_ready", o_exp_ready, 1);
      chk("rst_match", o_match_cnt, 0);
      chk("rst_error", o_error, 0);

      foreach (tbl[i]) begin
         cyc(tbl[i].en, tbl[i].ev, tbl[i].ed, tbl[i].dv, tbl[i].dd);
         chk($sformatf("tbl%0d_state", i), o_state, tbl[i].st);
         chk($sformatf("tbl%0d_level", i), o_fifo_level, tbl[i].lvl);
         chk($sformatf("tbl%0d_match", i), o_match_cnt, tbl[i].m);
         chk($sformatf("tbl%0d_error", i), o_error, tbl[i].err);
      end
      chk("basic_mism", o_mismatch_cnt, 0);

      // first-mismatch capture
      cyc(0, 0, 0, 0, 0);
      i_clear = 1; cyc(0, 0, 0, 0, 0); i_clear = 0;
      for (int i = 0; i < 8; i++) cyc(0, 1, 32'(i + 1), 0, 0);
      cyc(1, 0, 0, 0, 0);
      for (int j = 0; j < 3; j++) cyc(1, 0, 0, 1, 32'h5);
      for (int k = 0; k < 8; k++)
         cyc(1, 0, 0, 1, k == 4 ? 32'hDEAD : k == 6 ? 32'hBEEF : 32'(k + 1));
      cyc(1, 0, 0, 0, 0);
      chk("mm_mism", o_mismatch_cnt, 2);
      chk("mm_match", o_match_cnt, 6);
      chk("mm_error", o_error, 1);
      chk("mm_exp", o_first_err_exp, 32'h5);
      chk("mm_dut", o_first_err_dut, 32'hDEAD);
      chk("mm_idx", o_first_err_idx, 4);

      // full FIFO: 17th word must be held back
      cyc(0, 0, 0, 0, 0);
      i_clear = 1; cyc(0, 0, 0, 0, 0); i_clear = 0;
      chk("clr_mism", o_mismatch_cnt, 0);
      chk("clr_state", o_state, 0);
      for (int i = 0; i < 17; i++) begin
         cyc(0, 1, 32'(100 + i), 0, 0);
         if (i == 15) begin
            chk("full_ready", o_exp_ready, 0);
            chk("full_level16", o_fifo_level, 16);
         end
      end
      chk("full_level17", o_fifo_level, 16);
      cyc(1, 0, 0, 0, 0);
      for (int j = 0; j < 3; j++) cyc(1, 0, 0, 1, 0);
      for (int k = 0; k < 16; k++) cyc(1, 0, 0, 1, 32'(100 + k));
      cyc(1, 0, 0, 0, 0);
      chk("full_match", o_match_cnt, 16);
      chk("full_mism", o_mismatch_cnt, 0);
      chk("full_drain", o_fifo_level, 0);
      chk("full_ready2", o_exp_ready, 1);

      // underflow, second one with a same-cycle push that must not be popped
      cyc(0, 0, 0, 0, 0);
      i_clear = 1; cyc(0, 0, 0, 0, 0); i_clear = 0;
      cyc(1, 0, 0, 0, 0);
      for (int j = 0; j < 3; j++) cyc(1, 0, 0, 1, 0);
      cyc(1, 0, 0, 1, 32'h77);
      cyc(1, 1, 32'h77, 1, 32'h77);
      cyc(1, 0, 0, 0, 0);
      chk("uf_cnt", o_underflow_cnt, 2);
      chk("uf_error", o_error, 1);
      chk("uf_match", o_match_cnt, 0);
      chk("uf_level", o_fifo_level, 1);

      // wrap-around with simultaneous push and pop
      cyc(0, 0, 0, 0, 0);
      i_clear = 1; cyc(0, 0, 0, 0, 0); i_clear = 0;
      cyc(1, 0, 0, 0, 0);
      for (int j = 0; j < 3; j++) cyc(1, 0, 0, 1, 0);
      max_lvl = 0;
      for (int i = 0; i <= 40; i++) begin
         cyc(1, i < 40, 32'(i * 3 + 7), i > 0, 32'((i - 1) * 3 + 7));
         if (int'(o_fifo_level) > max_lvl) max_lvl = int'(o_fifo_level);
      end
      cyc(1, 0, 0, 0, 0);
      chk("wrap_match", o_match_cnt, 40);
      chk("wrap_mism", o_mismatch_cnt, 0);
      chk("wrap_maxlvl", 64'(max_lvl <= 2), 1);
      chk("wrap_level", o_fifo_level, 0);

      // mid-run clear with a result in flight, then reset mid-transfer
      cyc(1, 1, 32'h11, 0, 0);
      cyc(1, 1, 32'h22, 0, 0);
      cyc(1, 0, 0, 1, 32'h99);
      cyc(1, 0, 0, 1, 32'h22);
      chk("mc_mism_pre", o_mismatch_cnt, 1);
      chk("mc_err_pre", o_error, 1);
      i_clear = 1; cyc(1, 0, 0, 0, 0); i_clear = 0;
      chk("mc_state", o_state, 2);
      chk("mc_match", o_match_cnt, 0);
      chk("mc_mism", o_mismatch_cnt, 0);
      chk("mc_error", o_error, 0);
      chk("mc_level", o_fifo_level, 0);
      chk("mc_fexp", o_first_err_exp, 0);
      cyc(1, 0, 0, 0, 0);
      chk("mc_discard", o_match_cnt, 0);
      cyc(1, 1, 32'h33, 0, 0);
      i_reset = 1; cyc(1, 1, 32'h44, 1, 32'h33); i_reset = 0;
      chk("mr_state", o_state, 0);
      chk("mr_level", o_fifo_level, 0);
      chk("mr_ready", o_exp_ready, 1);
      chk("mr_match", o_match_cnt, 0);
      chk("mr_error", o_error, 0);
      cyc(0, 0, 0, 0, 0);
      chk("mr_match2", o_match_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
